fetch_queue: RTL and testbench

//  Instruction fetch stage that sits upstream of decode/execute. Owns the PC and issues

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake/bus bundle for fetch_queue: instruction-memory read port, downstream
// valid/ready output, and redirect/halt control.
interface fetch_queue_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              halted;

  // Fetch stage side
  modport master (
    output mem_rd_en, mem_addr, out_valid, out_instr, out_pc, halted,
    input  mem_rdata, out_ready, redirect, redirect_pc, halt
  );

  // Memory / downstream / control side
  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_instr, out_pc, halted,
    output mem_rdata, out_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency memory and buffers
// {pc,instr} in a prefetch queue. Optional counters enabled by FETCH_PERF_EN.
module fetch_queue #(
  parameter int              ADDR_W   = 4,
  parameter int              DATA_W   = 8,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetch_cnt,
  output logic [15:0]   perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

  typedef enum logic {ST_FETCH, ST_HALT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              inflight_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];

  logic              issue;
  logic              enq;
  logic              deq;
  logic              head_valid;
  logic [CNT_W:0]    occupancy;

  // Occupancy includes the read in flight so a returning word always has a slot.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    head_valid = (count_q != '0);
    issue      = ~reset & (state_q == ST_FETCH) & ~bus.halt & ~bus.redirect
                 & (occupancy < DEPTH_L);
    enq        = inflight_q & ~bus.redirect;
    deq        = head_valid & bus.out_ready & ~bus.redirect;
  end

  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = fetch_pc_q;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = head_valid ? instr_q[rd_ptr_q] : '0;
  assign bus.out_pc    = head_valid ? pc_q[rd_ptr_q]    : '0;
  assign bus.halted    = (state_q == ST_HALT);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (enq && (wr_ptr_q == PTR_W'(gi))) begin
          instr_q[gi] <= bus.mem_rdata;
          pc_q[gi]    <= pend_pc_q;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pend_pc_q  <= fetch_pc_q;
        fetch_pc_q <= fetch_pc_q + 1'b1;
      end
      if (bus.redirect) begin
        // Flush drops queued entries and the word returning this cycle.
        fetch_pc_q <= bus.redirect_pc;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        state_q    <= ST_FETCH;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({enq, deq})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        if (bus.halt) state_q <= ST_HALT;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue && (fetch_cnt_q != 16'hFFFF))
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (head_valid && !bus.out_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirect, PC wrap, halt,
// and mid-operation reset, with a 1-cycle-latency memory model.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   fetches;

  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(4), .DATA_W(8)) bus ();

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  fetch_queue #(.ADDR_W(4), .DATA_W(8), .DEPTH(4), .RESET_PC(4'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  logic [7:0] mem_arr [16];

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem_arr[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready && !bus.redirect)
      $display("xfer pc=%h instr=%h", bus.out_pc, bus.out_instr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: first cycle with reset low after reset state loaded.
  task automatic start();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 4'h0;
    bus.halt        = 1'b0;
    bus.mem_rdata   = 8'h00;
    for (int i = 0; i < 16; i++) mem_arr[i] = 8'(8'h10 + i);

    // Reset state
    tick();
    #1;
    chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_instr", 32'(bus.out_instr), 32'h0);
    chk("rst_pc", 32'(bus.out_pc), 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetch", 32'(perf_fetch_cnt), 32'd0);
    chk("rst_perf_stall", 32'(perf_stall_cnt), 32'd0);
`endif

    // 1: streaming from reset
    start();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("t1_rd_en", 32'(bus.mem_rd_en), 32'd1);
      chk("t1_addr", 32'(bus.mem_addr), 32'(k));
      chk("t1_valid", 32'(bus.out_valid), 32'(k >= 2));
      if (k >= 2) begin
        chk("t1_pc", 32'(bus.out_pc), 32'(k - 2));
        chk("t1_instr", 32'(bus.out_instr), 32'(8'h10 + k - 2));
      end
      tick();
    end

    // 2: backpressure fills the queue, head holds, then drains in order
    start();
    bus.out_ready = 1'b0;
    fetches = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      fetches += int'(bus.mem_rd_en);
      if (k >= 2) begin
        chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_hold_pc", 32'(bus.out_pc), 32'h0);
        chk("t2_hold_instr", 32'(bus.out_instr), 32'h10);
      end
      tick();
    end
    chk("t2_fetches", 32'(fetches), 32'd4);
`ifdef FETCH_PERF_EN
    chk("t2_perf_fetch", 32'(perf_fetch_cnt), 32'd4);
    chk("t2_perf_stall", 32'(perf_stall_cnt), 32'd8);
`endif
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("t2_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_pc", 32'(bus.out_pc), 32'(k));
      chk("t2_instr", 32'(bus.out_instr), 32'(8'h10 + k));
      tick();
    end

    // 3: redirect with queue partly full
    start();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 4'hA;
    #1;
    chk("t3_redir_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_redir_rd_en", 32'(bus.mem_rd_en), 32'd0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("t3_gap1_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_gap1_rd_en", 32'(bus.mem_rd_en), 32'd1);
    chk("t3_gap1_addr", 32'(bus.mem_addr), 32'hA);
    tick();
    #1;
    chk("t3_gap2_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_gap2_addr", 32'(bus.mem_addr), 32'hB);
    tick();
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t3_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_pc", 32'(bus.out_pc), 32'(4'hA + j));
      chk("t3_instr", 32'(bus.out_instr), 32'(8'h1A + j));
      tick();
    end

    // 4: PC wrap E,F,0,1
    start();
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 4'hE;
    #1;
    chk("t4_redir_rd_en", 32'(bus.mem_rd_en), 32'd0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("t4_addr_e", 32'(bus.mem_addr), 32'hE);
    tick();
    #1;
    chk("t4_addr_f", 32'(bus.mem_addr), 32'hF);
    tick();
    #1;
    chk("t4_addr_0", 32'(bus.mem_addr), 32'h0);
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("t4_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_pc", 32'(bus.out_pc), 32'(4'(4'hE + j)));
      chk("t4_instr", 32'(bus.out_instr), 32'(8'h10 + 4'(4'hE + j)));
      tick();
    end

    // 5: one-cycle halt while streaming, then redirect to 3
    start();
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.halt = 1'b1;
    #1;
    chk("t5_halt_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("t5_halt_pc", 32'(bus.out_pc), 32'h1);
    tick();
    bus.halt = 1'b0;
    #1;
    chk("t5_halted", 32'(bus.halted), 32'd1);
    chk("t5_drain_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_drain_pc", 32'(bus.out_pc), 32'h2);
    chk("t5_drain_rd_en", 32'(bus.mem_rd_en), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_idle_valid", 32'(bus.out_valid), 32'd0);
      chk("t5_idle_halted", 32'(bus.halted), 32'd1);
      chk("t5_idle_rd_en", 32'(bus.mem_rd_en), 32'd0);
      tick();
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 4'h3;
    #1;
    chk("t5_redir_halted", 32'(bus.halted), 32'd1);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("t5_resume_halted", 32'(bus.halted), 32'd0);
    chk("t5_resume_rd_en", 32'(bus.mem_rd_en), 32'd1);
    chk("t5_resume_addr", 32'(bus.mem_addr), 32'h3);
    tick();
    #1;
    chk("t5_resume_gap", 32'(bus.out_valid), 32'd0);
    tick();
    #1;
    chk("t5_resume_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_resume_pc", 32'(bus.out_pc), 32'h3);
    chk("t5_resume_instr", 32'(bus.out_instr), 32'h13);

    // 6: reset with occupied queue and a read in flight
    start();
    bus.out_ready = 1'b0;
    tick();
    tick();
    tick();
    #1;
    chk("t6_pre_rd_en", 32'(bus.mem_rd_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_halted", 32'(bus.halted), 32'd0);
    chk("t6_pc", 32'(bus.out_pc), 32'h0);
    chk("t6_instr", 32'(bus.out_instr), 32'h0);
    chk("t6_addr", 32'(bus.mem_addr), 32'h0);
    chk("t6_rd_en", 32'(bus.mem_rd_en), 32'd1);
`ifdef FETCH_PERF_EN
    chk("t6_perf_fetch0", 32'(perf_fetch_cnt), 32'd0);
    chk("t6_perf_stall0", 32'(perf_stall_cnt), 32'd0);
`endif
    tick();
    #1;
    chk("t6_gap_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_addr1", 32'(bus.mem_addr), 32'h1);
    tick();
    #1;
    chk("t6_first_valid", 32'(bus.out_valid), 32'd1);
    chk("t6_first_pc", 32'(bus.out_pc), 32'h0);
    chk("t6_first_instr", 32'(bus.out_instr), 32'h10);
    tick();
    tick();
    tick();
    #1;
`ifdef FETCH_PERF_EN
    chk("t6_perf_fetch", 32'(perf_fetch_cnt), 32'd4);
    chk("t6_perf_stall", 32'(perf_stall_cnt), 32'd3);
`endif
    chk("t6_held_pc", 32'(bus.out_pc), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
